// File: rtl/ioctl_upload_server_pkg.sv
// ---------------------------------------------------------------------------
// ioctl_pkg
//   Shared types and constants for the HPS upload (core-to-HPS) server.
//   - state_t     : sequencing FSM of the server (IDLE -> LO -> HI -> DONE)
//   - bf_state_t  : single-byte fetch engine state
//   - FILL_BYTE   : value returned for out-of-range or timed-out bytes
//   - IDX_*       : well-known ioctl_index values used across the core
// ---------------------------------------------------------------------------
package ioctl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        BF_IDLE = 2'd0,
        BF_REQ  = 2'd1,
        BF_FILL = 2'd2
    } bf_state_t;

    localparam logic [7:0] FILL_BYTE = 8'hFF;

    localparam logic [7:0] IDX_ROM   = 8'd0;
    localparam logic [7:0] IDX_DIP   = 8'd254;
    localparam logic [7:0] IDX_NVRAM = 8'd4;

    // True when a byte address lies at or beyond the populated part of the
    // memory. Both operands are zero-extended by the caller.
    function automatic logic past_end(input logic [31:0] addr, input logic [31:0] size);
        return addr >= size;
    endfunction

endpackage

// File: rtl/ioctl_upload_server_if.sv
// ---------------------------------------------------------------------------
// ioctl_upload_server_if
//   Bundles the hps_io upload signals and the byte-wide memory read port.
//
//   Handshakes:
//     HPS side : ioctl_rd is a one-cycle strobe; the server raises ioctl_wait
//                the following cycle and holds it until ioctl_din is valid.
//                The HPS does not issue another strobe while ioctl_wait is high.
//     Memory   : mem_req (with mem_addr) is held high until the memory returns
//                a one-cycle mem_ack; mem_data is valid in the ack cycle. The
//                server drops mem_req in the cycle after the ack, or after a
//                timeout with no ack.
//
//   Modports:
//     slave  : the upload server
//     master : the surrounding system (hps_io plus memory owner)
// ---------------------------------------------------------------------------
interface ioctl_upload_server_if #(
    parameter int AW = 10
);
    logic          ioctl_upload;
    logic [7:0]    ioctl_index;
    logic          ioctl_rd;
    logic [26:0]   ioctl_addr;
    logic [15:0]   ioctl_din;
    logic          ioctl_wait;

    logic [AW-1:0] mem_addr;
    logic          mem_req;
    logic          mem_ack;
    logic [7:0]    mem_data;

    modport slave (
        input  ioctl_upload,
        input  ioctl_index,
        input  ioctl_rd,
        input  ioctl_addr,
        output ioctl_din,
        output ioctl_wait,
        output mem_addr,
        output mem_req,
        input  mem_ack,
        input  mem_data
    );

    modport master (
        output ioctl_upload,
        output ioctl_index,
        output ioctl_rd,
        output ioctl_addr,
        input  ioctl_din,
        input  ioctl_wait,
        input  mem_addr,
        input  mem_req,
        output mem_ack,
        output mem_data
    );

endinterface

// File: rtl/ioctl_upload_server_byte_fetch.sv
// ---------------------------------------------------------------------------
// byte_fetch
//   Fetches one byte from the memory read port. A start pulse with an address
//   either launches a req/ack handshake or, when the address is flagged out of
//   range, produces FILL_BYTE one cycle later without touching the memory.
//   A request that sees no ack within TIMEOUT request cycles is abandoned and
//   also yields FILL_BYTE.
//
//   Ports:
//     clk_sys, reset_n  clock, async active-low reset
//     start             one-cycle launch strobe (ignored unless idle)
//     addr              byte address to fetch
//     oor               address is out of range: fill, no memory access
//     done              one-cycle completion strobe, byte_out valid with it
//     byte_out          fetched byte or FILL_BYTE
//     mem_addr/mem_req  memory request (registered)
//     mem_ack/mem_data  memory response
//     dbg_state         current engine state
// ---------------------------------------------------------------------------
module byte_fetch
    import ioctl_pkg::*;
#(
    parameter int AW      = 10,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] addr,
    input  logic          oor,
    output logic          done,
    output logic [7:0]    byte_out,
    output logic [AW-1:0] mem_addr,
    output logic          mem_req,
    input  logic          mem_ack,
    input  logic [7:0]    mem_data,
    output bf_state_t     dbg_state
);

    // Counter runs 0..TIMEOUT-1 over the request cycles.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    bf_state_t     state;
    logic [CW-1:0] cnt;
    logic          timeout_hit;

    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= BF_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                BF_IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        if (oor) begin
                            state <= BF_FILL;
                        end else begin
                            state    <= BF_REQ;
                            mem_req  <= 1'b1;
                            mem_addr <= addr;
                        end
                    end
                end
                BF_REQ: begin
                    // An ack in the final allowed cycle still wins over the timeout.
                    if (mem_ack || timeout_hit) begin
                        mem_req <= 1'b0;
                        state   <= BF_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BF_FILL: state <= BF_IDLE;
                default: state <= BF_IDLE;
            endcase
        end
    end

    // Completion is reported in the ack cycle so the sequencer can capture
    // mem_data directly; acks outside BF_REQ (late acks) are ignored here.
    assign done      = ((state == BF_REQ) && (mem_ack || timeout_hit)) || (state == BF_FILL);
    assign byte_out  = ((state == BF_REQ) && mem_ack) ? mem_data : FILL_BYTE;
    assign dbg_state = state;

endmodule

// File: rtl/ioctl_upload_server.sv
// ---------------------------------------------------------------------------
// ioctl_upload_server
//   Answers HPS upload reads for image INDEX with 16-bit words assembled from
//   a byte-wide on-core memory (hiscore/NVRAM style). Each read fetches the
//   even byte (low) then the odd byte (high) through one byte_fetch engine.
//   Bytes at or beyond SIZE, or requests with address bits above the memory
//   width set, read as FILL_BYTE without a memory access.
//
//   Ports:
//     clk_sys          system clock
//     reset_n          async active-low reset
//     bus (slave)      ioctl_upload/index/rd/addr in, ioctl_din/wait out,
//                      mem_addr/mem_req out, mem_ack/mem_data in
//     busy             high whenever the FSM is not IDLE
//     dbg_state        sequencer state
//     dbg_fetch_state  byte fetch engine state
// ---------------------------------------------------------------------------
module ioctl_upload_server
    import ioctl_pkg::*;
#(
    parameter logic [7:0] INDEX   = 8'd4,
    parameter int         AW      = 10,
    parameter int         SIZE    = 1024,
    parameter int         TIMEOUT = 255
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    ioctl_upload_server_if.slave  bus,
    output logic                  busy,
    output state_t                dbg_state,
    output bf_state_t             dbg_fetch_state
);

    state_t        state;
    logic [AW-2:0] base_word;    // word address; byte address = {base_word, lsb}
    logic          hi_nz;        // requested address lies above the memory window
    logic          aborted;      // session ended while a byte was in flight
    logic [7:0]    lo_byte;

    logic          fetch_start;
    logic [AW-1:0] fetch_addr;
    logic          fetch_oor;
    logic          fetch_done;
    logic [7:0]    fetch_byte;
    logic [AW-1:0] fetch_mem_addr;
    logic          fetch_mem_req;

    logic          sel;
    logic [AW-1:0] lo_addr_in;
    logic          hi_nz_in;
    logic [AW-1:0] hi_addr;
    logic          session_lost;
    logic          unused_addr_lsb;

    assign sel          = bus.ioctl_upload && (bus.ioctl_index == INDEX);
    assign lo_addr_in   = {bus.ioctl_addr[AW-1:1], 1'b0};
    assign hi_nz_in     = |bus.ioctl_addr[26:AW];
    // Base is even, so base+1 within AW bits is just the odd byte: no wrap.
    assign hi_addr      = {base_word, 1'b1};
    assign session_lost = aborted || !bus.ioctl_upload;

    // The word address selects both bytes; the byte lane bit is not used.
    assign unused_addr_lsb = bus.ioctl_addr[0];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            base_word      <= '0;
            hi_nz          <= 1'b0;
            aborted        <= 1'b0;
            lo_byte        <= 8'h00;
            fetch_start    <= 1'b0;
            fetch_addr     <= '0;
            fetch_oor      <= 1'b0;
            bus.ioctl_din  <= 16'h0000;
            bus.ioctl_wait <= 1'b0;
        end else begin
            fetch_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ioctl_rd && sel) begin
                        base_word      <= bus.ioctl_addr[AW-1:1];
                        hi_nz          <= hi_nz_in;
                        aborted        <= 1'b0;
                        fetch_start    <= 1'b1;
                        fetch_addr     <= lo_addr_in;
                        fetch_oor      <= hi_nz_in || past_end(32'(lo_addr_in), 32'(SIZE));
                        bus.ioctl_wait <= 1'b1;
                        state          <= LO;
                    end
                end
                LO: begin
                    if (!bus.ioctl_upload) begin
                        aborted <= 1'b1;
                    end
                    if (fetch_done) begin
                        lo_byte <= fetch_byte;
                        if (session_lost) begin
                            bus.ioctl_wait <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            fetch_start <= 1'b1;
                            fetch_addr  <= hi_addr;
                            fetch_oor   <= hi_nz || past_end(32'(hi_addr), 32'(SIZE));
                            state       <= HI;
                        end
                    end
                end
                HI: begin
                    if (!bus.ioctl_upload) begin
                        aborted <= 1'b1;
                    end
                    if (fetch_done) begin
                        bus.ioctl_wait <= 1'b0;
                        if (session_lost) begin
                            // Abandoned read: previous word stays on ioctl_din.
                            state <= IDLE;
                        end else begin
                            bus.ioctl_din <= {fetch_byte, lo_byte};
                            state         <= DONE;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    byte_fetch #(
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) u_fetch (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .start     (fetch_start),
        .addr      (fetch_addr),
        .oor       (fetch_oor),
        .done      (fetch_done),
        .byte_out  (fetch_byte),
        .mem_addr  (fetch_mem_addr),
        .mem_req   (fetch_mem_req),
        .mem_ack   (bus.mem_ack),
        .mem_data  (bus.mem_data),
        .dbg_state (dbg_fetch_state)
    );

    assign bus.mem_addr = fetch_mem_addr;
    assign bus.mem_req  = fetch_mem_req;
    assign busy         = (state != IDLE);
    assign dbg_state    = state;

endmodule

// File: tb/tb_ioctl_upload_server.sv
// ---------------------------------------------------------------------------
// tb_ioctl_upload_server
//   Directed bench for ioctl_upload_server (INDEX=4, AW=10, SIZE=1024,
//   TIMEOUT=255). Cycle 0 is the cycle the read strobe is high; outputs are
//   sampled on the falling edge. With an ack delay of d request cycles per
//   byte, ioctl_wait falls in cycle 5 + 2*d; a timeout behaves like d = 254.
// ---------------------------------------------------------------------------
module tb_ioctl_upload_server;
    import ioctl_pkg::*;

    localparam int AW = 10;

    logic      clk_sys;
    logic      reset_n;
    logic      busy;
    state_t    dbg_state;
    bf_state_t dbg_fetch_state;

    ioctl_upload_server_if #(.AW(AW)) bus ();

    ioctl_upload_server #(
        .INDEX   (8'd4),
        .AW      (AW),
        .SIZE    (1024),
        .TIMEOUT (255)
    ) dut (
        .clk_sys         (clk_sys),
        .reset_n         (reset_n),
        .bus             (bus),
        .busy            (busy),
        .dbg_state       (dbg_state),
        .dbg_fetch_state (dbg_fetch_state)
    );

    // ---------------- clock ----------------
    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [7:0] mem_arr [0:1023];
    logic       ack_en    = 1'b1;
    int         ack_delay = 0;
    logic       late_ack  = 1'b0;

    int         req_total     = 0;
    int         req_drop_viol = 0;
    int         run_len       = 0;
    logic       prev_req      = 1'b0;
    logic       prev_ack      = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- memory model ----------------
    // Acks after ack_delay request cycles; outside a request it drives late_ack.
    initial begin
        int req_age;
        req_age      = 0;
        bus.mem_ack  = 1'b0;
        bus.mem_data = 8'h00;
        forever begin
            @(posedge clk_sys);
            #1;
            if (bus.mem_req) begin
                bus.mem_ack  = ack_en && (req_age == ack_delay);
                bus.mem_data = mem_arr[bus.mem_addr];
                req_age++;
            end else begin
                bus.mem_ack  = late_ack;
                bus.mem_data = 8'h5A;
                req_age      = 0;
            end
        end
    end

    // ---------------- request monitor ----------------
    // Counts request cycles and flags any mem_req drop not preceded by an ack
    // or by a full 255-cycle timeout run.
    always @(negedge clk_sys) begin
        if (prev_req && !bus.mem_req && !prev_ack && run_len != 255 && reset_n)
            req_drop_viol++;
        if (bus.mem_req) begin
            req_total++;
            run_len = prev_req ? run_len + 1 : 1;
        end else begin
            run_len = 0;
        end
        prev_req = bus.mem_req;
        prev_ack = bus.mem_req && bus.mem_ack;
    end

    // ---------------- driver tasks ----------------
    // Issues one read strobe and waits for ioctl_wait to fall. extra_k injects
    // an illegal second strobe in that cycle; drop_k ends the session then.
    task automatic do_read(input string tag, input logic [26:0] addr,
                           input logic [15:0] exp_din, input int exp_lat,
                           input int extra_k, input int drop_k);
        int lat;
        lat = 0;
        @(posedge clk_sys); #1;
        bus.ioctl_addr = addr;
        bus.ioctl_rd   = 1'b1;
        @(posedge clk_sys); #1;
        bus.ioctl_rd   = 1'b0;
        for (int k = 1; k <= 700; k++) begin
            @(negedge clk_sys);
            if (k == 1) check({tag, " wait_c1"}, 32'(bus.ioctl_wait), 32'd1);
            if (!bus.ioctl_wait) begin
                lat = k;
                break;
            end
            if (k == extra_k) begin
                $display("note: injecting HPS strobe while ioctl_wait is high (%s)", tag);
                bus.ioctl_rd   = 1'b1;
                bus.ioctl_addr = 27'h10;
            end else if (k == extra_k + 1) begin
                bus.ioctl_rd = 1'b0;
            end
            if (k == drop_k) bus.ioctl_upload = 1'b0;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " din"}, 32'(bus.ioctl_din), 32'(exp_din));
    endtask

    // Issues a strobe that must be ignored and watches for any reaction.
    task automatic ignored_read(input string tag, input logic [15:0] exp_din);
        int wait_hi;
        int req_before;
        wait_hi    = 0;
        req_before = req_total;
        @(posedge clk_sys); #1;
        bus.ioctl_addr = 27'h10;
        bus.ioctl_rd   = 1'b1;
        @(posedge clk_sys); #1;
        bus.ioctl_rd   = 1'b0;
        repeat (8) begin
            @(negedge clk_sys);
            if (bus.ioctl_wait || busy) wait_hi++;
        end
        check({tag, " wait"}, 32'(wait_hi), 32'd0);
        check({tag, " mem_req"}, 32'(req_total - req_before), 32'd0);
        check({tag, " din"}, 32'(bus.ioctl_din), 32'(exp_din));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int req_before;

        reset_n          = 1'b0;
        bus.ioctl_upload = 1'b1;
        bus.ioctl_index  = IDX_NVRAM;
        bus.ioctl_rd     = 1'b0;
        bus.ioctl_addr   = 27'h0;

        for (int i = 0; i < 1024; i++) mem_arr[i] = 8'($urandom_range(0, 255));
        mem_arr[10'h010] = 8'h34;
        mem_arr[10'h011] = 8'h12;
        mem_arr[10'h020] = 8'h78;
        mem_arr[10'h021] = 8'h56;
        mem_arr[10'h3FE] = 8'hCD;
        mem_arr[10'h3FF] = 8'hAB;

        // Reset state
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check("rst din", 32'(bus.ioctl_din), 32'h0000);
        check("rst wait", 32'(bus.ioctl_wait), 32'd0);
        check("rst mem_req", 32'(bus.mem_req), 32'd0);
        check("rst mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst state", 32'(dbg_state), 32'(IDLE));
        reset_n = 1'b1;

        // Basic read, ack in the first request cycle
        ack_delay = 0;
        do_read("basic", 27'h10, 16'h1234, 5, 0, 0);
        check("basic busy_done", 32'(busy), 32'd1);
        @(negedge clk_sys);
        check("basic busy_after", 32'(busy), 32'd0);
        do_read("odd_addr", 27'h11, 16'h1234, 5, 0, 0);

        // Slow memory
        ack_delay = 7;
        do_read("slow", 27'h20, 16'h5678, 19, 0, 0);
        check("slow req_drop", 32'(req_drop_viol), 32'd0);

        // Range edges
        ack_delay = 0;
        do_read("top_word", 27'h3FE, 16'hABCD, 5, 0, 0);
        req_before = req_total;
        do_read("past_end", 27'h400, 16'hFFFF, 5, 0, 0);
        check("past_end no_req", 32'(req_total - req_before), 32'd0);
        req_before = req_total;
        do_read("high_bits", 27'h7FFFFFE, 16'hFFFF, 5, 0, 0);
        check("high_bits no_req", 32'(req_total - req_before), 32'd0);

        // Timeout on both bytes
        do_read("pre_timeout", 27'h20, 16'h5678, 5, 0, 0);
        ack_en     = 1'b0;
        req_before = req_total;
        do_read("timeout", 27'h10, 16'hFFFF, 513, 0, 0);
        check("timeout req_cycles", 32'(req_total - req_before), 32'd510);
        @(negedge clk_sys);
        late_ack = 1'b1;
        @(negedge clk_sys);
        late_ack = 1'b0;
        @(negedge clk_sys);
        check("late_ack busy", 32'(busy), 32'd0);
        check("late_ack wait", 32'(bus.ioctl_wait), 32'd0);
        check("late_ack din", 32'(bus.ioctl_din), 32'hFFFF);
        check("late_ack fetch", 32'(dbg_fetch_state), 32'(BF_IDLE));
        ack_en = 1'b1;

        // Wrong index and no session
        bus.ioctl_index = IDX_ROM;
        ignored_read("wrong_index", 16'hFFFF);
        bus.ioctl_index  = IDX_NVRAM;
        bus.ioctl_upload = 1'b0;
        ignored_read("no_session", 16'hFFFF);
        bus.ioctl_upload = 1'b1;

        // Strobe while busy must not disturb the read in flight
        ack_delay = 3;
        do_read("rd_busy", 27'h20, 16'h5678, 11, 2, 0);

        // Session ends during the low-byte wait
        ack_delay  = 6;
        req_before = req_total;
        do_read("abort", 27'h10, 16'h5678, 9, 0, 3);
        check("abort busy", 32'(busy), 32'd0);
        check("abort req_cycles", 32'(req_total - req_before), 32'd7);
        check("abort req_drop", 32'(req_drop_viol), 32'd0);
        bus.ioctl_upload = 1'b1;

        // Reset pulse while fetching the high byte
        ack_delay = 5;
        @(posedge clk_sys); #1;
        bus.ioctl_addr = 27'h10;
        bus.ioctl_rd   = 1'b1;
        @(posedge clk_sys); #1;
        bus.ioctl_rd   = 1'b0;
        repeat (10) @(negedge clk_sys);
        check("rst_hi state", 32'(dbg_state), 32'(HI));
        check("rst_hi mem_req", 32'(bus.mem_req), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_hi din", 32'(bus.ioctl_din), 32'h0000);
        check("rst_hi wait", 32'(bus.ioctl_wait), 32'd0);
        check("rst_hi req_drop", 32'(bus.mem_req), 32'd0);
        check("rst_hi mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_hi busy", 32'(busy), 32'd0);
        @(posedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;

        // Recovery after reset
        ack_delay = 0;
        do_read("recover", 27'h10, 16'h1234, 5, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
